// File: rtl/freq_count_bank.sv
// Multi-channel toggle-edge frequency monitor: counts synchronised edges over a 2^REFCNTWIDTH gate.
// Results appear with a one-cycle valid pulse after each terminal cycle; there is no backpressure.
module freq_count_bank #(
  parameter int NCH         = 16,
  parameter int REFCNTWIDTH = 24,
  parameter int CNTWIDTH    = 32,
  parameter int SYNCSTAGES  = 2
) (
  input  logic                    clk,
  input  logic                    aresetn,
  input  logic [NCH-1:0]          fin_tog,
  input  logic                    mode_cont,
  input  logic                    stb_start,
  input  logic                    stb_stop,
  input  logic                    clr_minmax,
  input  logic [CNTWIDTH-1:0]     thr_lo,
  input  logic [CNTWIDTH-1:0]     thr_hi,
  input  logic [NCH-1:0]          alarm_en,
  input  logic                    alarm_clr,
  output logic [NCH*CNTWIDTH-1:0] frequency,
  output logic [NCH*CNTWIDTH-1:0] fmin,
  output logic [NCH*CNTWIDTH-1:0] fmax,
  output logic [NCH-1:0]          ovf,
  output logic [NCH-1:0]          alarm,
  output logic                    valid,
  output logic                    busy,
  output logic [15:0]             nwin
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [CNTWIDTH-1:0] CMAX = '1;

  state_t                  r_state;
  logic [REFCNTWIDTH-1:0]  r_refcnt;
  logic [CNTWIDTH-1:0]     r_cnt [NCH];
  logic [NCH-1:0]          r_sat;
  logic [NCH-1:0]          r_sync [SYNCSTAGES];
  logic [NCH-1:0]          r_dly;

  logic [NCH-1:0]          w_edge;
  logic [CNTWIDTH-1:0]     w_next [NCH];
  logic [NCH-1:0]          w_lost;
  logic [NCH-1:0]          w_hit;
  logic                    w_term;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNCSTAGES; i++) r_sync[i] <= '0;
      r_dly <= '0;
    end else begin
      r_sync[0] <= fin_tog;
      for (int i = 1; i < SYNCSTAGES; i++) r_sync[i] <= r_sync[i-1];
      r_dly <= r_sync[SYNCSTAGES-1];
    end
  end

  assign w_edge = r_sync[SYNCSTAGES-1] ^ r_dly;
  assign w_term = (r_state == S_RUN) && !stb_stop && (r_refcnt == '1);
  assign busy   = (r_state == S_RUN);

  // w_lost flags an edge that arrived while the counter was already pinned at all ones
  always_comb begin
    w_lost = '0;
    w_hit  = '0;
    for (int j = 0; j < NCH; j++) begin
      w_next[j] = (r_cnt[j] == CMAX) ? CMAX : r_cnt[j] + CNTWIDTH'(w_edge[j]);
      w_lost[j] = (r_cnt[j] == CMAX) && w_edge[j];
      w_hit[j]  = alarm_en[j] && ((w_next[j] < thr_lo) || (w_next[j] > thr_hi));
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= S_IDLE;
      r_refcnt  <= '0;
      r_sat     <= '0;
      for (int j = 0; j < NCH; j++) r_cnt[j] <= '0;
      frequency <= '0;
      ovf       <= '0;
      valid     <= 1'b0;
      nwin      <= '0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (stb_start && !stb_stop) begin
            r_state  <= S_RUN;
            r_refcnt <= '0;
            r_sat    <= '0;
            for (int j = 0; j < NCH; j++) r_cnt[j] <= '0;
          end
        end
        S_RUN: begin
          if (stb_stop) begin
            r_state <= S_IDLE;
          end else if (w_term) begin
            r_refcnt <= '0;
            r_sat    <= '0;
            for (int j = 0; j < NCH; j++) begin
              r_cnt[j] <= '0;
              frequency[j*CNTWIDTH +: CNTWIDTH] <= w_next[j];
            end
            ovf   <= r_sat | w_lost;
            valid <= 1'b1;
            nwin  <= nwin + 16'd1;
            if (!mode_cont) r_state <= S_IDLE;
          end else begin
            r_refcnt <= r_refcnt + 1'b1;
            r_sat    <= r_sat | w_lost;
            for (int j = 0; j < NCH; j++) r_cnt[j] <= w_next[j];
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A clear coinciding with a terminal loads the new result into both trackers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      fmin  <= '1;
      fmax  <= '0;
      alarm <= '0;
    end else begin
      for (int j = 0; j < NCH; j++) begin
        if (w_term) begin
          if (clr_minmax || (w_next[j] < fmin[j*CNTWIDTH +: CNTWIDTH]))
            fmin[j*CNTWIDTH +: CNTWIDTH] <= w_next[j];
          if (clr_minmax || (w_next[j] > fmax[j*CNTWIDTH +: CNTWIDTH]))
            fmax[j*CNTWIDTH +: CNTWIDTH] <= w_next[j];
        end else if (clr_minmax) begin
          fmin[j*CNTWIDTH +: CNTWIDTH] <= CMAX;
          fmax[j*CNTWIDTH +: CNTWIDTH] <= '0;
        end
      end
      alarm <= (alarm_clr ? '0 : alarm) | (w_term ? w_hit : '0);
    end
  end

endmodule

// File: tb/tb_freq_count_bank.sv
// Scoreboard bench for freq_count_bank: an 8-bit-count instance and a 3-bit-count instance share stimulus.
module tb_freq_count_bank;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [1:0]  fin_tog;
  logic        mode_cont, stb_start, stb_stop, clr_minmax, alarm_clr;
  logic [7:0]  thr_lo, thr_hi;
  logic [1:0]  alarm_en;

  logic [15:0] a_freq, a_fmin, a_fmax;
  logic [1:0]  a_ovf, a_alarm;
  logic        a_valid, a_busy;
  logic [15:0] a_nwin;

  logic [5:0]  b_freq, b_fmin, b_fmax;
  logic [1:0]  b_ovf, b_alarm;
  logic        b_valid, b_busy;
  logic [15:0] b_nwin;

  always #5 clk = ~clk;

  freq_count_bank #(.NCH(2), .REFCNTWIDTH(4), .CNTWIDTH(8), .SYNCSTAGES(2)) u_dut (
    .clk(clk), .aresetn(aresetn), .fin_tog(fin_tog), .mode_cont(mode_cont),
    .stb_start(stb_start), .stb_stop(stb_stop), .clr_minmax(clr_minmax),
    .thr_lo(thr_lo), .thr_hi(thr_hi), .alarm_en(alarm_en), .alarm_clr(alarm_clr),
    .frequency(a_freq), .fmin(a_fmin), .fmax(a_fmax), .ovf(a_ovf), .alarm(a_alarm),
    .valid(a_valid), .busy(a_busy), .nwin(a_nwin));

  freq_count_bank #(.NCH(2), .REFCNTWIDTH(4), .CNTWIDTH(3), .SYNCSTAGES(2)) u_sat (
    .clk(clk), .aresetn(aresetn), .fin_tog(fin_tog), .mode_cont(mode_cont),
    .stb_start(stb_start), .stb_stop(stb_stop), .clr_minmax(clr_minmax),
    .thr_lo(thr_lo[2:0]), .thr_hi(thr_hi[2:0]), .alarm_en(alarm_en), .alarm_clr(alarm_clr),
    .frequency(b_freq), .fmin(b_fmin), .fmax(b_fmax), .ovf(b_ovf), .alarm(b_alarm),
    .valid(b_valid), .busy(b_busy), .nwin(b_nwin));

  typedef struct {
    logic [7:0]  f0, f1, mn0, mx0;
    logic [1:0]  al;
    logic [15:0] nw;
    int          gap;
  } exp_t;

  typedef struct {
    logic [2:0] f0;
    logic       ov0;
  } expb_t;

  exp_t  qa [$];
  expb_t qb [$];
  int    pass_cnt = 0;
  int    tot_cnt  = 0;
  int    cyc      = 0;
  int    last_vld = 0;
  logic [15:0] pat [2];
  logic [3:0]  ph = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Each channel toggles on the cycles marked in its 16-bit pattern, so a 16-cycle gate sees popcount edges
  initial begin
    fin_tog = 2'b00;
    pat[0]  = 16'h0;
    pat[1]  = 16'h0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) if (pat[j][ph]) fin_tog[j] = ~fin_tog[j];
      ph = ph + 4'd1;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) chk("unexpected_valid_a", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("freq0", {24'd0, a_freq[7:0]}, {24'd0, e.f0});
        chk("freq1", {24'd0, a_freq[15:8]}, {24'd0, e.f1});
        chk("fmin0", {24'd0, a_fmin[7:0]}, {24'd0, e.mn0});
        chk("fmax0", {24'd0, a_fmax[7:0]}, {24'd0, e.mx0});
        chk("alarm", {30'd0, a_alarm}, {30'd0, e.al});
        chk("nwin", {16'd0, a_nwin}, {16'd0, e.nw});
        if (e.gap != 0) chk("valid_gap", cyc - last_vld, e.gap);
      end
      last_vld = cyc;
    end
  end

  always @(negedge clk) begin
    if (b_valid) begin
      if (qb.size() == 0) chk("unexpected_valid_b", 32'd1, 32'd0);
      else begin
        expb_t e;
        e = qb.pop_front();
        chk("sat_freq0", {29'd0, b_freq[2:0]}, {29'd0, e.f0});
        chk("sat_ovf0", {31'd0, b_ovf[0]}, {31'd0, e.ov0});
      end
    end
  end

  task automatic push(input logic [7:0] f0, f1, mn, mx, input logic [1:0] al,
                      input logic [15:0] nw, input int gap, input logic [2:0] bf, input logic bo);
    exp_t  e;
    expb_t b;
    e.f0 = f0; e.f1 = f1; e.mn0 = mn; e.mx0 = mx; e.al = al; e.nw = nw; e.gap = gap;
    b.f0 = bf; b.ov0 = bo;
    qa.push_back(e);
    qb.push_back(b);
  endtask

  task automatic set_pat(input logic [15:0] p0, p1);
    pat[0] = p0;
    pat[1] = p1;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_win(input logic do_clr, input logic do_aclr);
    int busy_n;
    busy_n = 0;
    @(negedge clk);
    stb_start = 1'b1;
    @(negedge clk);
    stb_start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      if (a_busy) busy_n++;
      if (i == 16) begin
        clr_minmax = do_clr;
        alarm_clr  = do_aclr;
      end
    end
    @(negedge clk);
    clr_minmax = 1'b0;
    alarm_clr  = 1'b0;
    chk("busy_cycles", busy_n, 16);
    chk("busy_after", {31'd0, a_busy}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    aresetn = 1'b0; mode_cont = 1'b0; stb_start = 1'b0; stb_stop = 1'b0;
    clr_minmax = 1'b0; alarm_clr = 1'b0; thr_lo = 8'd0; thr_hi = 8'd255; alarm_en = 2'b00;
    repeat (3) @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_freq", {16'd0, a_freq}, 32'd0);
    chk("rst_fmin", {16'd0, a_fmin}, 32'h0000_FFFF);
    chk("rst_fmax", {16'd0, a_fmax}, 32'd0);
    chk("rst_flags", {26'd0, a_ovf, a_alarm, a_valid, a_busy}, 32'd0);
    chk("rst_nwin", {16'd0, a_nwin}, 32'd0);

    set_pat(16'h5555, 16'h0000);
    push(8'd8, 8'd0, 8'd8, 8'd8, 2'b00, 16'd1, 0, 3'd7, 1'b1);
    run_win(1'b0, 1'b0);
    push(8'd8, 8'd0, 8'd8, 8'd8, 2'b00, 16'd2, 0, 3'd7, 1'b1);
    run_win(1'b0, 1'b0);
    chk("nwin_after_two", {16'd0, a_nwin}, 32'd2);

    set_pat(16'h1111, 16'h0000);
    push(8'd4, 8'd0, 8'd4, 8'd8, 2'b00, 16'd3, 0, 3'd4, 1'b0);
    run_win(1'b0, 1'b0);
    set_pat(16'h7777, 16'h0000);
    push(8'd12, 8'd0, 8'd4, 8'd12, 2'b00, 16'd4, 0, 3'd7, 1'b1);
    run_win(1'b0, 1'b0);
    set_pat(16'h0333, 16'h0000);
    push(8'd6, 8'd0, 8'd6, 8'd6, 2'b00, 16'd5, 0, 3'd6, 1'b0);
    run_win(1'b1, 1'b0);

    // Continuous: three back-to-back windows, an edge on every cycle including each terminal
    set_pat(16'hFFFF, 16'h0000);
    push(8'd16, 8'd0, 8'd6, 8'd16, 2'b00, 16'd6, 0, 3'd7, 1'b1);
    push(8'd16, 8'd0, 8'd6, 8'd16, 2'b00, 16'd7, 16, 3'd7, 1'b1);
    push(8'd16, 8'd0, 8'd6, 8'd16, 2'b00, 16'd8, 16, 3'd7, 1'b1);
    mode_cont = 1'b1;
    @(negedge clk);
    stb_start = 1'b1;
    @(negedge clk);
    stb_start = 1'b0;
    repeat (36) @(negedge clk);
    mode_cont = 1'b0;
    repeat (16) @(negedge clk);
    chk("cont_busy_after", {31'd0, a_busy}, 32'd0);

    thr_lo = 8'd5; thr_hi = 8'd10; alarm_en = 2'b01;
    set_pat(16'h1111, 16'h1111);
    push(8'd4, 8'd4, 8'd4, 8'd16, 2'b01, 16'd9, 0, 3'd4, 1'b0);
    run_win(1'b0, 1'b0);
    set_pat(16'h5555, 16'h5555);
    push(8'd8, 8'd8, 8'd4, 8'd16, 2'b01, 16'd10, 0, 3'd7, 1'b1);
    run_win(1'b0, 1'b0);
    set_pat(16'h1111, 16'h1111);
    push(8'd4, 8'd4, 8'd4, 8'd16, 2'b01, 16'd11, 0, 3'd4, 1'b0);
    run_win(1'b0, 1'b1);
    alarm_clr = 1'b1;
    @(negedge clk);
    alarm_clr = 1'b0;
    chk("alarm_cleared", {30'd0, a_alarm}, 32'd0);

    thr_lo = 8'd10; thr_hi = 8'd5; alarm_en = 2'b11;
    set_pat(16'h5555, 16'h5555);
    push(8'd8, 8'd8, 8'd4, 8'd16, 2'b11, 16'd12, 0, 3'd7, 1'b1);
    run_win(1'b0, 1'b0);

    // Abort at cycle 7: no result, previous values held
    @(negedge clk);
    stb_start = 1'b1;
    @(negedge clk);
    stb_start = 1'b0;
    repeat (6) @(negedge clk);
    stb_stop = 1'b1;
    @(negedge clk);
    stb_stop = 1'b0;
    chk("stop_busy", {31'd0, a_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("stop_freq", {16'd0, a_freq}, 32'h0000_0808);
    chk("stop_nwin", {16'd0, a_nwin}, 32'd12);

    stb_start = 1'b1;
    stb_stop  = 1'b1;
    @(negedge clk);
    stb_start = 1'b0;
    stb_stop  = 1'b0;
    chk("startstop_idle", {31'd0, a_busy}, 32'd0);
    repeat (20) @(negedge clk);
    chk("startstop_idle_late", {31'd0, a_busy}, 32'd0);

    stb_start = 1'b1;
    @(negedge clk);
    stb_start = 1'b0;
    repeat (8) @(negedge clk);
    aresetn = 1'b0;
    @(negedge clk);
    chk("midrst_freq", {16'd0, a_freq}, 32'd0);
    chk("midrst_fmin", {16'd0, a_fmin}, 32'h0000_FFFF);
    chk("midrst_fmax", {16'd0, a_fmax}, 32'd0);
    chk("midrst_flags", {26'd0, a_ovf, a_alarm, a_valid, a_busy}, 32'd0);
    chk("midrst_nwin", {16'd0, a_nwin}, 32'd0);
    chk("midrst_sat_ovf", {30'd0, b_ovf}, 32'd0);
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (24) @(negedge clk);
    chk("post_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("pending_a", qa.size(), 32'd0);
    chk("pending_b", qb.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule

// File: doc/freq_count_bank.md
Name: freq_count_bank

Overview:
- Multi-channel frequency/activity monitor for board clocks. Generalises the single-channel per-clock frequency counter.
- Each channel is fed by a toggle bit that is pre-divided in its source domain. The bank counts transitions on every channel over a common reference gate.
- Adds single-shot/continuous modes, per-channel min/max tracking, threshold alarms and a window counter.
- Sits in board config on cfgclk; outputs map to cfgregs.

Parameters:
- NCH, 16, number of monitored channels.
- REFCNTWIDTH, 24, gate window = 2^REFCNTWIDTH clk cycles.
- CNTWIDTH, 32, width of each per-channel count/result.
- SYNCSTAGES, 2, synchroniser depth on fin_tog (min 2).

Ports:
- clk, input, 1, config clock; all logic is in this domain.
- aresetn, input, 1, asynchronous active-low reset.
- fin_tog, input, NCH, per-channel toggle bits, asynchronous to clk.
- mode_cont, input, 1, 1 = continuous windows, 0 = single-shot.
- stb_start, input, 1, one-cycle start strobe.
- stb_stop, input, 1, one-cycle abort strobe.
- clr_minmax, input, 1, clears min/max tracking.
- thr_lo, input, CNTWIDTH, alarm lower bound (common to all channels).
- thr_hi, input, CNTWIDTH, alarm upper bound (common to all channels).
- alarm_en, input, NCH, per-channel alarm enable.
- alarm_clr, input, 1, clears sticky alarms.
- frequency, output, NCH*CNTWIDTH, last result; channel j at [j*CNTWIDTH +: CNTWIDTH].
- fmin, output, NCH*CNTWIDTH, minimum result since clear.
- fmax, output, NCH*CNTWIDTH, maximum result since clear.
- ovf, output, NCH, result saturated in the last window.
- alarm, output, NCH, sticky out-of-range flag.
- valid, output, 1, one-cycle pulse when results update.
- busy, output, 1, high in RUN state.
- nwin, output, 16, completed windows since reset, wraps.

Behaviour:
- Reset (async assert, sync release): state IDLE; frequency = 0; fmax = 0; fmin = all ones; ovf = 0; alarm = 0; valid = 0; busy = 0; nwin = 0; refcnt = 0; channel counters = 0; sync chains = 0.
- Input path: fin_tog[j] passes through SYNCSTAGES flops, then one more flop. edge[j] = XOR of the last two. Both toggle edges count. Input-to-edge latency is SYNCSTAGES+1 cycles.
- FSM IDLE -> RUN on stb_start (stb_stop low). On entry, refcnt = 0 and counters = 0. busy = 1 in RUN.
- In RUN, refcnt increments every cycle. cnt[j] increments on edge[j] and saturates at all ones.
- Terminal cycle is refcnt == all ones. On it:
  - frequency[j] <= cnt[j] + edge[j], saturating.
  - ovf[j] <= 1 if saturation occurred in the window.
  - cnt[j] <= 0 and refcnt <= 0, so windows are contiguous, exactly 2^REFCNTWIDTH cycles each, with no dead cycle.
- valid pulses one cycle after the terminal cycle, aligned with the new frequency, fmin, fmax, alarm and nwin.
- After the terminal cycle: if mode_cont = 1, stay in RUN; else go to IDLE. mode_cont is sampled at the terminal cycle.
- stb_stop in RUN: go to IDLE next cycle, discard the partial window, no valid. Results keep their previous values.
- stb_start in RUN is ignored. stb_start and stb_stop in the same cycle: stop wins.
- Min/max update at the terminal: fmin[j] = min(fmin[j], new); fmax[j] = max(fmax[j], new).
- clr_minmax sets fmin = all ones and fmax = 0. If it coincides with a terminal cycle, the new result is loaded into both fmin and fmax (clear then update).
- Alarm: at the terminal, alarm[j] is set if alarm_en[j] and (new < thr_lo or new > thr_hi). Compare is unsigned.
  - Sticky until alarm_clr.
  - alarm_clr in the same cycle as a new set: set wins.
  - thr_lo > thr_hi means every enabled channel alarms.
- nwin increments once per completed window and wraps 0xFFFF -> 0. Aborted windows do not count.
- Reset asserted mid-window: all state returns to reset values immediately; no valid.

Test Plan:
- REFCNTWIDTH=4, NCH=2, single-shot; ch0 toggles every 2 clk, ch1 static; start -> busy for 16 cycles, one valid; second run gives freq0 = 8, freq1 = 0, busy = 0 after, nwin = 2.
- Continuous, ch0 toggles every clk -> each valid spaced exactly 16 cycles, freq0 = 16 from the second window onward; no missed edges across the window boundary (edge on the terminal cycle is counted in that window).
- CNTWIDTH=3, ch0 toggles every clk -> freq0 = 7, ovf[0] = 1; then slow toggle (4 per window) -> freq0 = 4, ovf[0] = 0.
- Min/max and clr_minmax: sequence of 8, 4, 12 -> fmin = 4, fmax = 12. clr_minmax on the terminal cycle of a window giving 6 -> fmin = fmax = 6.
- Alarms: thr_lo = 5, thr_hi = 10, alarm_en = 2'b01, results 4/4 -> alarm = 2'b01, stays after an in-range window; alarm_clr coincident with another out-of-range terminal -> alarm stays 1.
- stb_stop at cycle 7 of a window -> no valid, frequency unchanged, nwin unchanged. start+stop same cycle in IDLE -> stays IDLE. aresetn low mid-RUN -> all outputs at reset values.
